// File: rtl/chan_access_sequencer.sv
//------------------------------------------------------------------------------
// chan_access_sequencer : round-robin channel-bus sequencer (setup/strobe/hold)
// Optional feature macro: CHSEQ_TPULSE_ALIGN_EN (strobe start aligned to TPULSE)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module chan_access_sequencer #(
   parameter int NREQ       = 2,
   parameter int STROBE_CYC = 2
) (
   input  logic                   SIM_CLK,
   input  logic                   SIM_RST,
   input  logic                   GOJAM,
`ifdef CHSEQ_TPULSE_ALIGN_EN
   input  logic                   TPULSE,
`endif
   input  logic [NREQ-1:0]        req,
   input  logic [2*NREQ-1:0]      req_op,
   input  logic [6*NREQ-1:0]      req_chan,
   input  logic [16*NREQ-1:0]     req_wdata,
   output logic [NREQ-1:0]        ack,
   output logic [15:0]            rdata,
   output logic                   busy,
   output logic [7:0]             XT_n,
   output logic [7:0]             XB_n,
   output logic                   RCHG_n,
   output logic                   WCHG_n,
   output logic                   CCHG_n,
   output logic [15:0]            WL,
   input  logic [15:0]            CH
);

   localparam int               PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PTR_W:0]   NREQ_W   = (PTR_W+1)'(NREQ);
   localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NREQ - 1);
   localparam logic [3:0]       CNT_INIT = 4'(STROBE_CYC - 1);

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_HOLD   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [1:0]        op_q, op_d;
   logic [5:0]        chan_q, chan_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       rdata_q, rdata_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [7:0]        xt_n_q, xt_n_d;
   logic [7:0]        xb_n_q, xb_n_d;
   logic              rchg_n_q, rchg_n_d;
   logic              wchg_n_q, wchg_n_d;
   logic              cchg_n_q, cchg_n_d;
   logic [15:0]       wl_q, wl_d;

   logic              abort;
   logic              setup_go;
   logic              gnt_found;
   logic [PTR_W-1:0]  gnt_idx;
   logic [PTR_W:0]    cand;

   logic [1:0]        op_arr    [NREQ];
   logic [5:0]        chan_arr  [NREQ];
   logic [15:0]       wdata_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_req_unpack
      assign op_arr[g]    = req_op[2*g +: 2];
      assign chan_arr[g]  = req_chan[6*g +: 6];
      assign wdata_arr[g] = req_wdata[16*g +: 16];
   end

`ifdef CHSEQ_TPULSE_ALIGN_EN
   assign setup_go = TPULSE;
`else
   assign setup_go = 1'b1;
`endif

   assign abort = SIM_RST | GOJAM;

   // Search downward so the lowest offset after rr_ptr is the one that sticks.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = rr_ptr_q;
      cand      = '0;
      for (int i = NREQ; i >= 1; i--) begin
         cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         if (req[cand[PTR_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      op_d     = op_q;
      chan_d   = chan_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               state_d  = S_SETUP;
               rr_ptr_d = gnt_idx;
               op_d     = op_arr[gnt_idx];
               chan_d   = chan_arr[gnt_idx];
               wdata_d  = wdata_arr[gnt_idx];
               rdata_d  = '0;
            end
         end
         S_SETUP: begin
            if (op_q == OP_RSV) begin
               state_d = S_DONE;
            end else if (setup_go) begin
               state_d = S_STROBE;
               cnt_d   = CNT_INIT;
            end
         end
         S_STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = S_HOLD;
               if (op_q == OP_RD) begin
                  rdata_d = CH;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HOLD:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort discards any grant made this cycle so the pointer is untouched.
      if (abort) begin
         state_d  = S_IDLE;
         rr_ptr_d = rr_ptr_q;
         rdata_d  = '0;
      end
   end

   // Bus outputs are registered from the next state so they change cleanly on the edge.
   always_comb begin
      ack_d    = '0;
      xt_n_d   = 8'hFF;
      xb_n_d   = 8'hFF;
      rchg_n_d = 1'b1;
      wchg_n_d = 1'b1;
      cchg_n_d = 1'b1;
      wl_d     = '0;

      case (state_d)
         S_SETUP, S_STROBE, S_HOLD: begin
            xt_n_d = ~(8'h01 << chan_d[5:3]);
            xb_n_d = ~(8'h01 << chan_d[2:0]);
            if (op_d == OP_WR) begin
               wl_d = wdata_d;
            end
         end
         S_DONE: begin
            ack_d[rr_ptr_d] = 1'b1;
         end
         default: begin
            ack_d = '0;
         end
      endcase

      if (state_d == S_STROBE) begin
         case (op_d)
            OP_RD:   rchg_n_d = 1'b0;
            OP_WR:   wchg_n_d = 1'b0;
            OP_CLR:  cchg_n_d = 1'b0;
            default: rchg_n_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= PTR_INIT;
         op_q     <= OP_RD;
         chan_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         ack_q    <= '0;
         xt_n_q   <= 8'hFF;
         xb_n_q   <= 8'hFF;
         rchg_n_q <= 1'b1;
         wchg_n_q <= 1'b1;
         cchg_n_q <= 1'b1;
         wl_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         op_q     <= op_d;
         chan_q   <= chan_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
         xt_n_q   <= xt_n_d;
         xb_n_q   <= xb_n_d;
         rchg_n_q <= rchg_n_d;
         wchg_n_q <= wchg_n_d;
         cchg_n_q <= cchg_n_d;
         wl_q     <= wl_d;
      end
   end

   assign ack    = ack_q;
   assign rdata  = rdata_q;
   assign busy   = (state_q != S_IDLE);
   assign XT_n   = xt_n_q;
   assign XB_n   = xb_n_q;
   assign RCHG_n = rchg_n_q;
   assign WCHG_n = wchg_n_q;
   assign CCHG_n = cchg_n_q;
   assign WL     = wl_q;

endmodule

`default_nettype wire
